// File: rtl/demux_1_8_buf_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : demux_1_8_buf_pkg
// Description : Shared core constants and helpers for the 1:8 buffered demux.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
package demux_1_8_buf_pkg;

    localparam int c_CORE_DATA_WIDTH = 64;
    localparam int c_NUM_DEST        = 8;

    typedef logic [2:0] dest_sel_t;

    function automatic logic [c_NUM_DEST-1:0] sel_to_onehot(input dest_sel_t sel);
        logic [c_NUM_DEST-1:0] v;
        v = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/demux_1_8_buf_dec_3_8.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : dec_3_8
// Description : Combinational 3-to-8 one-hot decoder with enable.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
module dec_3_8
    import demux_1_8_buf_pkg::*;
(
    input  logic       i_en,
    input  dest_sel_t  i_sel,
    output logic [7:0] o_onehot
);

    always_comb begin
        o_onehot = 8'h00;
        if (i_en) begin
            o_onehot = sel_to_onehot(i_sel);
        end
    end

endmodule

`default_nettype wire

// File: rtl/demux_1_8_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : demux_1_8_buf
// Description : 1-to-8 demultiplexer with valid/ready handshake and a
//               two-entry (head + skid) buffer for full-rate streaming.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
module demux_1_8_buf
    import demux_1_8_buf_pkg::*;
#(
    parameter int DATA_WIDTH = c_CORE_DATA_WIDTH
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [2:0]            in_sel,
    output logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [7:0]            out_valid,
    input  logic [7:0]            in_ready,
    output logic [1:0]            out_count
);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_TWO   = 2'd2;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_head_data;
    dest_sel_t             r_head_sel;
    logic [DATA_WIDTH-1:0] r_skid_data;
    dest_sel_t             r_skid_sel;

    logic w_accept;
    logic w_drain;
    logic w_head_valid;

    assign out_ready    = !in_rst && (r_state != c_ST_TWO);
    assign w_accept     = in_valid & out_ready;
    assign w_head_valid = (r_state != c_ST_EMPTY);
    // Only the selected consumer's ready bit can be set in this AND.
    assign w_drain      = |(out_valid & in_ready);

    dec_3_8 u_dec (
        .i_en     (w_head_valid),
        .i_sel    (r_head_sel),
        .o_onehot (out_valid)
    );

    assign out_data  = r_head_data;
    assign out_count = r_state;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state     <= c_ST_EMPTY;
            r_head_data <= '0;
            r_head_sel  <= '0;
            r_skid_data <= '0;
            r_skid_sel  <= '0;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_accept) begin
                        r_head_data <= in_data;
                        r_head_sel  <= in_sel;
                        r_state     <= c_ST_ONE;
                    end
                end
                c_ST_ONE: begin
                    if (w_accept && w_drain) begin
                        r_head_data <= in_data;
                        r_head_sel  <= in_sel;
                    end else if (w_accept) begin
                        r_skid_data <= in_data;
                        r_skid_sel  <= in_sel;
                        r_state     <= c_ST_TWO;
                    end else if (w_drain) begin
                        r_state     <= c_ST_EMPTY;
                    end
                end
                c_ST_TWO: begin
                    if (w_drain) begin
                        r_head_data <= r_skid_data;
                        r_head_sel  <= r_skid_sel;
                        r_state     <= c_ST_ONE;
                    end
                end
                default: begin
                    r_state <= c_ST_EMPTY;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_demux_1_8_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_demux_1_8_buf
// Description : Directed self-checking bench for demux_1_8_buf.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_demux_1_8_buf;

    localparam int c_DW = 64;

    logic            in_clk = 1'b0;
    logic            in_rst;
    logic            in_valid;
    logic [c_DW-1:0] in_data;
    logic [2:0]      in_sel;
    logic            out_ready;
    logic [c_DW-1:0] out_data;
    logic [7:0]      out_valid;
    logic [7:0]      in_ready;
    logic [1:0]      out_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 in_clk = ~in_clk;

    demux_1_8_buf #(.DATA_WIDTH(c_DW)) dut (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .in_ready  (in_ready),
        .out_count (out_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before inputs change or checks run.
    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic [2:0] s);
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
    endtask

    initial begin
        in_rst   = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'h1234_5678_9ABC_DEF0;
        in_sel   = 3'd2;
        in_ready = 8'h00;

        // Reset held two cycles with a word offered
        step();
        step();
        chk("rst_valid", {56'd0, out_valid}, 64'h0);
        chk("rst_data",  out_data, 64'h0);
        chk("rst_count", {62'd0, out_count}, 64'd0);
        chk("rst_ready", {63'd0, out_ready}, 64'd0);
        in_rst   = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_ready", {63'd0, out_ready}, 64'd1);

        // Single word to consumer 5
        send(64'hDEAD_BEEF_0000_0001, 3'd5);
        in_ready = 8'h20;
        step();
        in_valid = 1'b0;
        chk("single_valid", {56'd0, out_valid}, 64'h20);
        chk("single_data",  out_data, 64'hDEAD_BEEF_0000_0001);
        chk("single_count", {62'd0, out_count}, 64'd1);
        step();
        chk("single_drained_valid", {56'd0, out_valid}, 64'h0);
        chk("single_drained_count", {62'd0, out_count}, 64'd0);

        // Streaming 8 words, one per cycle
        in_ready = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            send(64'(i), 3'(i));
            step();
            chk("stream_valid", {56'd0, out_valid}, 64'(1) << i);
            chk("stream_data",  out_data, 64'(i));
            chk("stream_ready", {63'd0, out_ready}, 64'd1);
            chk("stream_count", {62'd0, out_count}, 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_tail_count", {62'd0, out_count}, 64'd0);
        chk("stream_tail_valid", {56'd0, out_valid}, 64'h0);

        // Backpressure: A (sel 3) then B (sel 1) fill head and skid
        in_ready = 8'h00;
        send(64'hAAAA_0000_0000_000A, 3'd3);
        step();
        send(64'hBBBB_0000_0000_000B, 3'd1);
        step();
        chk("skid_count", {62'd0, out_count}, 64'd2);
        chk("skid_ready", {63'd0, out_ready}, 64'd0);
        chk("skid_valid", {56'd0, out_valid}, 64'h08);
        chk("skid_data",  out_data, 64'hAAAA_0000_0000_000A);
        // Word offered while full must not be captured
        send(64'hCCCC_0000_0000_000C, 3'd7);
        step();
        in_valid = 1'b0;
        chk("full_hold_count", {62'd0, out_count}, 64'd2);
        chk("full_hold_data",  out_data, 64'hAAAA_0000_0000_000A);
        in_ready = 8'h08;
        step();
        chk("skid_pop_valid", {56'd0, out_valid}, 64'h02);
        chk("skid_pop_data",  out_data, 64'hBBBB_0000_0000_000B);
        chk("skid_pop_ready", {63'd0, out_ready}, 64'd1);
        chk("skid_pop_count", {62'd0, out_count}, 64'd1);
        in_ready = 8'h02;
        step();
        chk("skid_empty_count", {62'd0, out_count}, 64'd0);

        // Ready from the wrong consumer must not drain the head
        in_ready = 8'hBF;
        send(64'h6666_0000_0000_0006, 3'd6);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wrong_rdy_valid", {56'd0, out_valid}, 64'h40);
            chk("wrong_rdy_data",  out_data, 64'h6666_0000_0000_0006);
        end
        in_ready = 8'h40;
        step();
        chk("wrong_rdy_drain_count", {62'd0, out_count}, 64'd0);

        // Reset with two words buffered discards both
        in_ready = 8'h00;
        send(64'hD000_0000_0000_000D, 3'd2);
        step();
        send(64'hE000_0000_0000_000E, 3'd4);
        step();
        in_valid = 1'b0;
        chk("pre_rst_count", {62'd0, out_count}, 64'd2);
        in_rst = 1'b1;
        step();
        chk("mid_rst_valid", {56'd0, out_valid}, 64'h0);
        chk("mid_rst_count", {62'd0, out_count}, 64'd0);
        chk("mid_rst_ready", {63'd0, out_ready}, 64'd0);
        chk("mid_rst_data",  out_data, 64'h0);
        in_rst   = 1'b0;
        in_ready = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("after_rst_valid", {56'd0, out_valid}, 64'h0);
            chk("after_rst_count", {62'd0, out_count}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
